// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central sequencer for the PC and the IF_ID / ID_EX / EX_MEM pipeline
// registers. It produces per-stage load enables and flush (bubble) strobes
// from three hazard sources. Priority is fixed at mem_busy > branch_taken >
// load_use. Outputs are combinational (Mealy) from state, inputs and rst_n.
// State, the branch-penalty counter and the performance counters are
// registered. The pipeline registers give flush priority over enable.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   id_rs1, id_rs2       source register indices of the instruction in ID
//   id_uses_rs1/_rs2     the ID instruction actually reads rs1 / rs2
//   ex_mem_read, ex_rd   the EX instruction is a load, and its destination
//   branch_taken         EX resolved a taken branch/jump this cycle
//   mem_busy             data memory not ready; freeze the whole pipe
//   pc_en, if_id_en, id_ex_en, ex_mem_en   stage load enables
//   if_id_flush, id_ex_flush               stage bubble strobes
//   stall_cnt            saturating count of cycles with pc_en = 0
//   flush_cnt            saturating count of taken-branch events
//
// Build option:
//   PIPE_CTRL_PERF_CNT_EN  defined   -> stall_cnt / flush_cnt implemented
//                          undefined -> no counter flops, both outputs tied 0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W          = 5,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2
    } state_t;

    // Counter value loaded on a taken branch: the branch cycle itself is the
    // first flush cycle, so BR_FLUSH covers the remaining BRANCH_PENALTY-1.
    localparam logic [3:0] PEN_RELOAD = 4'(BRANCH_PENALTY - 1);
    localparam bit         PEN_MULTI  = (BRANCH_PENALTY > 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] pen_r;
    logic [3:0] pen_nxt_s;
    logic       load_use_s;
    logic       stall_evt_s;
    logic       flush_evt_s;

    // Load-use hazard detect; register 0 is hardwired so never stalls.
    always_comb begin
        load_use_s = ex_mem_read && (ex_rd != {REG_W{1'b0}}) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    // Next-state, penalty counter and Mealy output decode.
    always_comb begin
        state_nxt_s = state_r;
        pen_nxt_s   = pen_r;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;

        if (!rst_n) begin
            // Reset forces a full bubble regardless of the clock.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt_s = ST_RUN;
            pen_nxt_s   = 4'd0;
        end else if (mem_busy) begin
            // Freeze: everything holds, only the stall counter advances.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            stall_evt_s = 1'b1;
        end else if (branch_taken) begin
            // Same handling from every state, including reload in BR_FLUSH.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt_s = 1'b1;
            if (PEN_MULTI) begin
                state_nxt_s = ST_BR_FLUSH;
                pen_nxt_s   = PEN_RELOAD;
            end else begin
                state_nxt_s = ST_RUN;
                pen_nxt_s   = 4'd0;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_use_s) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_evt_s = 1'b1;
                        state_nxt_s = ST_LOAD_STALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_LOAD_STALL: begin
                    // The load has moved to MEM; the hazard is resolved.
                    state_nxt_s = ST_RUN;
                end
                ST_BR_FLUSH: begin
                    if_id_flush = 1'b1;
                    if (pen_r <= 4'd1) begin
                        state_nxt_s = ST_RUN;
                        pen_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_BR_FLUSH;
                        pen_nxt_s   = pen_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    pen_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and branch-penalty counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            pen_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            pen_r   <= pen_nxt_s;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    logic unused_evt_s;

    // Event strobes have no consumer without the counters.
    always_comb begin
        unused_evt_s = stall_evt_s ^ flush_evt_s;
    end

    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_hazard_ctrl (BRANCH_PENALTY = 3, CNT_W = 4 so that
// counter saturation is reachable). A table of per-cycle records holds the
// inputs and hand-derived expected outputs; expectations are queued when a
// cycle is driven and popped when the outputs are sampled. Hand-written
// sequences cover saturation and asynchronous reset mid-stall / mid-flush.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int PEN   = 3;

    localparam logic [5:0] O_DEF   = 6'b110101;
    localparam logic [5:0] O_LU    = 6'b000111;
    localparam logic [5:0] O_BR    = 6'b111111;
    localparam logic [5:0] O_BRF   = 6'b111101;
    localparam logic [5:0] O_FRZ   = 6'b000000;
    localparam logic [5:0] O_RST   = 6'b001010;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_hazard_ctrl #(
        .REG_W(REG_W),
        .BRANCH_PENALTY(PEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd),
        .branch_taken(branch_taken),
        .mem_busy(mem_busy),
        .pc_en(pc_en),
        .if_id_en(if_id_en),
        .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             br;
        logic             busy;
        logic             mr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic             u1;
        logic [REG_W-1:0] rs2;
        logic             u2;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] outs;
        int         s;
        int         f;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] outs;
        int         s;
        int         f;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    function automatic in_t mk_in(logic br, logic busy, logic mr, int rd,
                                  int rs1, logic u1, int rs2, logic u2);
        in_t r;
        r.br   = br;
        r.busy = busy;
        r.mr   = mr;
        r.rd   = REG_W'(rd);
        r.rs1  = REG_W'(rs1);
        r.u1   = u1;
        r.rs2  = REG_W'(rs2);
        r.u2   = u2;
        return r;
    endfunction

    function automatic vec_t mk(in_t i, logic [5:0] o, int s, int f);
        vec_t v;
        v.in   = i;
        v.outs = o;
        v.s    = s;
        v.f    = f;
        return v;
    endfunction

    // Counter expectation depends on whether the counters are built.
    function automatic int ec(int v);
`ifdef PIPE_CTRL_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic drive(input in_t i);
        branch_taken = i.br;
        mem_busy     = i.busy;
        ex_mem_read  = i.mr;
        ex_rd        = i.rd;
        id_rs1       = i.rs1;
        id_uses_rs1  = i.u1;
        id_rs2       = i.rs2;
        id_uses_rs2  = i.u2;
    endtask

    task automatic push_exp(input string name, input logic [5:0] o,
                            input int s, input int f);
        exp_t e;
        e.name = name;
        e.outs = o;
        e.s    = ec(s);
        e.f    = ec(f);
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [5:0] act;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, need 1");
        end else begin
            e   = sb.pop_front();
            act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
            n_tests++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL %s outs: got %b, need %b", e.name, act, e.outs);
            end
            n_tests++;
            if (stall_cnt !== CNT_W'(e.s)) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d, need %0d", e.name, stall_cnt, e.s);
            end
            n_tests++;
            if (flush_cnt !== CNT_W'(e.f)) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d, need %0d", e.name, flush_cnt, e.f);
            end
        end
    endtask

    // One clock cycle: drive after the falling edge, sample before the rise.
    task automatic cycle(input string name, input in_t i, input logic [5:0] o,
                         input int s, input int f);
        @(negedge clk);
        drive(i);
        push_exp(name, o, s, f);
        #2;
        check_pop();
    endtask

    vec_t tbl[30];
    in_t  IDLE, LU1, ZR, LU2, NOUSE, NORD, BR, BRLU, BUSY, BUSYBR, BUSYLU2;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        IDLE    = mk_in(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        LU1     = mk_in(1'b0, 1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0);
        ZR      = mk_in(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b1);
        LU2     = mk_in(1'b0, 1'b0, 1'b1, 5, 5, 1'b0, 5, 1'b1);
        NOUSE   = mk_in(1'b0, 1'b0, 1'b1, 7, 7, 1'b0, 0, 1'b0);
        NORD    = mk_in(1'b0, 1'b0, 1'b0, 3, 3, 1'b1, 0, 1'b0);
        BR      = mk_in(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        BRLU    = mk_in(1'b1, 1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0);
        BUSY    = mk_in(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        BUSYBR  = mk_in(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        BUSYLU2 = mk_in(1'b0, 1'b1, 1'b1, 5, 5, 1'b0, 5, 1'b1);

        tbl[0]  = mk(IDLE,   O_DEF, 0, 0);
        tbl[1]  = mk(LU1,    O_LU,  0, 0);
        tbl[2]  = mk(LU1,    O_DEF, 1, 0);
        tbl[3]  = mk(IDLE,   O_DEF, 1, 0);
        tbl[4]  = mk(ZR,     O_DEF, 1, 0);
        tbl[5]  = mk(BR,     O_BR,  1, 0);
        tbl[6]  = mk(IDLE,   O_BRF, 1, 1);
        tbl[7]  = mk(IDLE,   O_BRF, 1, 1);
        tbl[8]  = mk(IDLE,   O_DEF, 1, 1);
        tbl[9]  = mk(BRLU,   O_BR,  1, 1);
        tbl[10] = mk(LU1,    O_BRF, 1, 2);
        tbl[11] = mk(BUSY,   O_FRZ, 1, 2);
        tbl[12] = mk(BUSY,   O_FRZ, 2, 2);
        tbl[13] = mk(BUSY,   O_FRZ, 3, 2);
        tbl[14] = mk(BUSY,   O_FRZ, 4, 2);
        tbl[15] = mk(IDLE,   O_BRF, 5, 2);
        tbl[16] = mk(IDLE,   O_DEF, 5, 2);
        tbl[17] = mk(BUSYBR, O_FRZ, 5, 2);
        tbl[18] = mk(LU1,    O_LU,  6, 2);
        tbl[19] = mk(BRLU,   O_BR,  7, 2);
        tbl[20] = mk(BR,     O_BR,  7, 3);
        tbl[21] = mk(IDLE,   O_BRF, 7, 4);
        tbl[22] = mk(IDLE,   O_BRF, 7, 4);
        tbl[23] = mk(IDLE,   O_DEF, 7, 4);
        tbl[24] = mk(LU2,    O_LU,  7, 4);
        tbl[25] = mk(BUSYLU2,O_FRZ, 8, 4);
        tbl[26] = mk(LU2,    O_DEF, 9, 4);
        tbl[27] = mk(NOUSE,  O_DEF, 9, 4);
        tbl[28] = mk(NORD,   O_DEF, 9, 4);
        tbl[29] = mk(IDLE,   O_DEF, 9, 4);

        // Reset state.
        rst_n = 1'b0;
        drive(IDLE);
        #3;
        push_exp("reset", O_RST, 0, 0);
        check_pop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 30; k++) begin
            cycle($sformatf("vec%0d", k), tbl[k].in, tbl[k].outs, tbl[k].s, tbl[k].f);
        end

        // Stall counter saturation (starts at 9, CNT_W = 4).
        for (int k = 0; k < 10; k++) begin
            cycle($sformatf("sat_stall%0d", k), BUSY, O_FRZ, (9 + k > 15) ? 15 : 9 + k, 4);
        end
        // Back-to-back branches: each reloads the flush, flush_cnt saturates.
        for (int k = 0; k < 12; k++) begin
            cycle($sformatf("sat_flush%0d", k), BR, O_BR, 15, (4 + k > 15) ? 15 : 4 + k);
        end
        cycle("sat_tail0", IDLE, O_BRF, 15, 15);
        cycle("sat_tail1", IDLE, O_BRF, 15, 15);
        cycle("sat_tail2", IDLE, O_DEF, 15, 15);

        // Reset pulsed during LOAD_STALL.
        cycle("rs_lu", LU1, O_LU, 15, 15);
        @(negedge clk);
        drive(LU1);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rs_lu_async", O_RST, 0, 0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        push_exp("rs_lu_release", O_LU, 0, 0);
        check_pop();
        cycle("rs_lu_after", LU1, O_DEF, 1, 0);

        // Reset pulsed during BR_FLUSH: no residual bubble after release.
        cycle("rs_br", BR, O_BR, 1, 0);
        cycle("rs_br_fl", IDLE, O_BRF, 1, 1);
        @(negedge clk);
        drive(IDLE);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rs_br_async", O_RST, 0, 0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        push_exp("rs_br_release", O_DEF, 0, 0);
        check_pop();
        cycle("rs_br_after", IDLE, O_DEF, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the pipeline registers (IF_ID, ID_EX, EX_MEM) and the PC.
- Generates per-stage load enables and flush (bubble) strobes from three sources: load-use hazards, taken branches resolved in EX, and data-memory wait.
- Sits beside the datapath; all register enables and flushes route from here.
- Pipeline registers give flush priority over enable.

Parameters:
- REG_W, 5: register-index width.
- BRANCH_PENALTY, 1: cycles IF_ID is flushed after a taken branch. Legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  REG_W  source reg 1 of instruction in ID
- id_rs2  in  REG_W  source reg 2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination reg of instruction in EX
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory not ready; freeze the pipe
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF_ID load enable
- if_id_flush  out  1  IF_ID clear to bubble
- id_ex_en  out  1  ID_EX load enable
- id_ex_flush  out  1  ID_EX clear to bubble
- ex_mem_en  out  1  EX_MEM load enable
- stall_cnt  out  CNT_W  cycles with pc_en=0 (saturating)
- flush_cnt  out  CNT_W  taken-branch events (saturating)

Behaviour:
- Reset:
  - State = RUN, penalty counter = 0, stall_cnt = flush_cnt = 0.
  - While rst_n=0, outputs are forced: all enables 0, if_id_flush = id_ex_flush = 1.
  - Outputs are combinational from state, inputs and rst_n (Mealy). State and counters are registered.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority every cycle: mem_busy > branch_taken > load_use.
- Freeze (mem_busy=1, any state):
  - All enables 0, both flushes 0.
  - State, penalty counter and flush_cnt hold; stall_cnt increments.
- Default outputs (no event): all enables 1, flushes 0.
- RUN:
  - branch_taken: enables 1; if_id_flush = id_ex_flush = 1; flush_cnt +1. Next state is BR_FLUSH with counter = BRANCH_PENALTY-1 if BRANCH_PENALTY>1, else RUN.
  - Else load_use: pc_en = if_id_en = 0; id_ex_flush = 1; id_ex_en = ex_mem_en = 1; stall_cnt +1. Next state LOAD_STALL.
  - Else: defaults, stay in RUN.
- LOAD_STALL (one cycle):
  - load_use is ignored.
  - branch_taken is handled exactly as in RUN.
  - Otherwise defaults, next state RUN.
- BR_FLUSH:
  - if_id_flush = 1, other outputs at defaults; load_use ignored.
  - Counter decrements each cycle; on the cycle counter==1, next state RUN.
  - A new branch_taken here behaves as in RUN: reloads the counter, flush_cnt +1.
- ex_rd = 0 never triggers a stall (register 0 is hardwired).
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-stall or mid-flush: immediate return to RUN, no residual bubble after release.

Optional Feature:
- PIPE_CTRL_PERF_CNT_EN
  - Defined: stall_cnt and flush_cnt are implemented as above.
  - Undefined: no counter flops; both outputs are tied to 0. Control behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_uses_rs1=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then the next cycle all enables=1 while the same inputs are held; stall_cnt=1.
- ex_rd=0 with a matching id_rs2=0 → no stall; pc_en stays 1.
- BRANCH_PENALTY=3, branch_taken pulse → if_id_flush high 3 cycles, id_ex_flush high 1 cycle, flush_cnt=1.
- branch_taken and load_use in the same RUN cycle → branch wins: pc_en=1, both flushes=1, no LOAD_STALL.
- mem_busy 4 cycles in the middle of BR_FLUSH (penalty 3) → all enables 0 for 4 cycles, flush resumes with the remaining count, stall_cnt=4.
- rst_n pulsed low during LOAD_STALL → outputs forced to reset values asynchronously; after release, state RUN, counters 0.
